periph_async_rx: RTL and testbench
==================================

// Module: periph_async_rx
// PURPOSE
//  Peripheral-side partner of the CPU send/ack requester: consumes `send` plus a bundled data word.
//  Synchronizes `send` into the local clock domain and completes a 4-phase handshake by driving `ack`.
//  Each accepted word is buffered in a small FIFO and presented downstream on a valid/ready port.
//  Sits directly downstream of the CPU handshake FSM, between it and the peripheral datapath.
// PARAMETERS
//  DW     8  width of data_in / out_data
//  DEPTH  4  FIFO entries; power of 2, >=2
//  SYNC   2  synchronizer flops on send; >=2
// PORTS
//  clk        in   1          single clock; all state on posedge clk
//  rst        in   1          asynchronous, active-high reset
//  send       in   1          request from CPU side; asynchronous to clk
//  data_in    in   DW         bundled data; stable while send=1
//  ack        out  1          handshake acknowledge to CPU side; registered
//  out_data   out  DW         FIFO head word
//  out_valid  out  1          FIFO not empty
//  out_ready  in   1          downstream accepts head when out_valid & out_ready
//  full       out  1          FIFO holds DEPTH words
//  count      out  log2(DEPTH)+1  current occupancy
//  xfer_cnt   out  16         completed handshakes; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst=1): ack=0, out_valid=0, full=0, count=0, xfer_cnt=0, FSM=IDLE.
//   Sync chain and FIFO pointers=0. out_data is don't-care.
//  send_s = send after SYNC flops. Data is captured only from data_in, never through the sync chain.
//  FSM (registered, 2 states):
//   IDLE (ack=0):
//     send_s=1 & !full -> push data_in, go to ACK.
//     send_s=1 & full  -> stay in IDLE, ack held 0 (back-pressure stalls CPU).
//     send_s=0         -> stay in IDLE.
//   ACK (ack=1):
//     send_s=0 -> go to IDLE, xfer_cnt+1.
//     else     -> stay in ACK; no further push.
//  Latency with SYNC=2:
//   ack rises on the 3rd posedge after send rises (if not full).
//   ack falls on the 3rd posedge after send falls.
//  Exactly one push per 4-phase cycle; a held send never double-pushes.
//  FIFO:
//   push = IDLE->ACK transition; pop = out_valid & out_ready.
//   full is computed from registered count; a same-cycle pop does not unblock a push.
//   Push and pop in the same cycle (count>0): count unchanged, data order preserved.
//   Pop when empty is ignored. Read/write pointers carry an extra wrap bit; wrap is modulo DEPTH.
//   out_data = mem[rd_ptr]; it is valid the cycle after push (first-word latency 1 clk).
//  Reset mid-handshake: ack drops immediately (async) and buffered words are discarded.
//   The CPU side sees ack=0; a still-high send is re-accepted as a new transfer after reset.
// STRUCTURE
//  Shared package/header async_hs_pkg: FSM state encodings (HS_IDLE=0, HS_ACK=1) and a CLOG2 helper.
//  Sub-module hs_sync_fifo (DW, DEPTH): push/pop/full/empty/count. Reused by the CPU-side TX path.
//  Top level: SYNC-deep flop chain, 2-state FSM, xfer_cnt.
// TESTING
//  1. Single transfer: data_in=0xA5, send 0->1 -> ack=1 at 3rd edge; send->0 -> ack=0 at 3rd edge.
//     out_valid=1, out_data=0xA5, xfer_cnt=1.
//  2. Burst: 4 transfers 0x01..0x04 with out_ready=0 -> full=1, count=4.
//     5th send held high -> ack stays 0. Pop one -> 5th is acked; data order 01,02,03,04,05.
//  3. Simultaneous: count=2 while a push and a pop land in the same cycle -> count stays 2, order intact.
//  4. send held high 50 cycles -> exactly one push, ack held 1, count+1 only.
//  5. rst pulsed while ack=1 -> ack=0 and count=0 within the reset.
//     With send still high after release -> new push, xfer_cnt counts from 0.
//  6. Pointer wrap: 3*DEPTH+1 transfers with continuous out_ready=1 -> all words out in order, no loss.

Source files
------------

// File: rtl/async_hs_pkg.sv
// Shared definitions for the CPU/peripheral send-ack handshake blocks.
// Holds the handshake FSM encoding, the transfer-counter width and a constant log2 helper.
package async_hs_pkg;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    localparam int XFER_W = 16;

    // Ceiling log2 for sizing pointers and counters from parameters.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/periph_async_rx_if.sv
// Bundle of the handshake request side and the downstream valid/ready side of periph_async_rx.
// master = CPU/downstream environment, slave = the receiver block.
interface periph_async_rx_if
    import async_hs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);

    logic                   send;
    logic [DW-1:0]          data_in;
    logic                   ack;
    logic [DW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   full;
    logic [clog2(DEPTH):0]  count;
    logic [XFER_W-1:0]      xfer_cnt;

    modport master (
        output send, data_in, out_ready,
        input  ack, out_data, out_valid, full, count, xfer_cnt
    );

    modport slave (
        input  send, data_in, out_ready,
        output ack, out_data, out_valid, full, count, xfer_cnt
    );

endinterface

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; occupancy and flags derive from registered pointers.
// Shared by the RX and TX sides of the handshake path.
module hs_sync_fifo
    import async_hs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DW-1:0]         data_i,
    input  logic                  pop_i,
    output logic [DW-1:0]         data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] count_o
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Flags come from registered state only, so a same-cycle pop never frees a slot for a push.
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign full_o   = (count_o == (AW+1)'(DEPTH));
    assign empty_o  = (count_o == '0);
    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/periph_async_rx.sv
// Peripheral-side receiver: synchronizes send, completes the 4-phase ack handshake,
// buffers each accepted word and presents it on a valid/ready port.
module periph_async_rx
    import async_hs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input logic               clk,
    input logic               rst,
    periph_async_rx_if.slave  bus
);

    logic [SYNC-1:0]       sync_q;
    logic                  send_s;
    hs_state_e             state_q;
    logic                  ack_q;
    logic [XFER_W-1:0]     xfer_cnt_q;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Only the request crosses domains; data_in is bundled and sampled directly once send_s is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC-2:0], bus.send};
    end

    assign send_s = sync_q[SYNC-1];
    assign push   = (state_q == HS_IDLE) & send_s & ~fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HS_IDLE;
            ack_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else if (state_q == HS_IDLE) begin
            if (push) begin
                state_q <= HS_ACK;
                ack_q   <= 1'b1;
            end
        end else if (!send_s) begin
            state_q    <= HS_IDLE;
            ack_q      <= 1'b0;
            xfer_cnt_q <= xfer_cnt_q + XFER_W'(1);
        end
    end

    hs_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (bus.data_in),
        .pop_i   (bus.out_ready),
        .data_o  (bus.out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.count)
    );

    assign bus.ack       = ack_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_periph_async_rx.sv
// Directed bench for periph_async_rx (DW=8, DEPTH=4, SYNC=2): inputs driven and outputs
// sampled on the falling edge, expected values written out by hand per scenario.
module tb_periph_async_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_xfer = 0;
    logic mon_en = 1'b0;
    logic [7:0] rx_q[$];

    periph_async_rx_if #(.DW(8), .DEPTH(4)) bus();

    periph_async_rx #(.DW(8), .DEPTH(4), .SYNC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Records each word as it is handed downstream (valid & ready seen before the popping edge).
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic wait_ack(input logic lvl, input string what);
        int n;
        n = 0;
        while (bus.ack !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.ack !== lvl) begin
            $display("FAIL %s: ack=%b, required %b within 20 cycles", what, bus.ack, lvl);
            fails++;
        end
    endtask

    task automatic send_word(input logic [7:0] d);
        bus.data_in = d;
        bus.send    = 1'b1;
        wait_ack(1'b1, "ack_rise");
        bus.send    = 1'b0;
        wait_ack(1'b0, "ack_fall");
        exp_xfer++;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string what);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
            $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h",
                     what, bus.out_valid, bus.out_data, exp);
            fails++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (bus.ack !== 1'b0 || bus.out_valid !== 1'b0 || bus.full !== 1'b0 ||
            bus.count !== 3'd0 || bus.xfer_cnt !== 16'd0) begin
            $display("FAIL reset_state: ack=%b valid=%b full=%b count=%0d xfer=%0d, required all 0",
                     bus.ack, bus.out_valid, bus.full, bus.count, bus.xfer_cnt);
            fails++;
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ack !== 1'b0 || bus.count !== 3'd0) begin
            $display("FAIL reset_release: ack=%b count=%0d, required 0/0", bus.ack, bus.count);
            fails++;
        end
    endtask

    task automatic test_single();
        bus.data_in = 8'hA5;
        bus.send    = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.ack !== 1'b0) begin
            $display("FAIL single_ack_early: ack=%b after 2 edges, required 0", bus.ack);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (bus.ack !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            $display("FAIL single_ack_rise: ack=%b valid=%b data=%h after 3 edges, required 1/1/a5",
                     bus.ack, bus.out_valid, bus.out_data);
            fails++;
        end
        bus.send = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.ack !== 1'b1) begin
            $display("FAIL single_ack_hold: ack=%b 2 edges after send fell, required 1", bus.ack);
            fails++;
        end
        @(negedge clk);
        exp_xfer++;
        tests++;
        if (bus.ack !== 1'b0 || bus.xfer_cnt !== 16'd1) begin
            $display("FAIL single_ack_fall: ack=%b xfer=%0d, required 0/1", bus.ack, bus.xfer_cnt);
            fails++;
        end
        pop_check(8'hA5, "single_data");
    endtask

    task automatic test_burst();
        for (int i = 1; i <= 4; i++) send_word(8'(i));
        tests++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
            $display("FAIL burst_full: full=%b count=%0d, required 1/4", bus.full, bus.count);
            fails++;
        end
        bus.data_in = 8'h05;
        bus.send    = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (bus.ack !== 1'b0 || bus.count !== 3'd4) begin
            $display("FAIL burst_backpressure: ack=%b count=%0d, required 0/4", bus.ack, bus.count);
            fails++;
        end
        pop_check(8'h01, "burst_pop1");
        wait_ack(1'b1, "burst_fifth_ack");
        tests++;
        if (bus.count !== 3'd4) begin
            $display("FAIL burst_fifth_push: count=%0d, required 4", bus.count);
            fails++;
        end
        bus.send = 1'b0;
        wait_ack(1'b0, "burst_fifth_fall");
        exp_xfer++;
        for (int i = 2; i <= 5; i++) pop_check(8'(i), "burst_order");
        tests++;
        if (bus.count !== 3'd0 || bus.xfer_cnt !== 16'(exp_xfer)) begin
            $display("FAIL burst_end: count=%0d xfer=%0d, required 0/%0d",
                     bus.count, bus.xfer_cnt, exp_xfer);
            fails++;
        end
    endtask

    task automatic test_simultaneous();
        send_word(8'h10);
        send_word(8'h11);
        bus.data_in = 8'h12;
        bus.send    = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.out_data !== 8'h10 || bus.count !== 3'd2) begin
            $display("FAIL simul_pre: data=%h count=%0d, required 10/2", bus.out_data, bus.count);
            fails++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests++;
        if (bus.ack !== 1'b1 || bus.count !== 3'd2) begin
            $display("FAIL simul_count: ack=%b count=%0d, required 1/2", bus.ack, bus.count);
            fails++;
        end
        bus.send = 1'b0;
        wait_ack(1'b0, "simul_fall");
        exp_xfer++;
        pop_check(8'h11, "simul_order1");
        pop_check(8'h12, "simul_order2");
    endtask

    task automatic test_held();
        bus.data_in = 8'h77;
        bus.send    = 1'b1;
        wait_ack(1'b1, "held_rise");
        repeat (50) @(negedge clk);
        tests++;
        if (bus.ack !== 1'b1 || bus.count !== 3'd1 || bus.xfer_cnt !== 16'(exp_xfer)) begin
            $display("FAIL held_single_push: ack=%b count=%0d xfer=%0d, required 1/1/%0d",
                     bus.ack, bus.count, bus.xfer_cnt, exp_xfer);
            fails++;
        end
        bus.send = 1'b0;
        wait_ack(1'b0, "held_fall");
        exp_xfer++;
        tests++;
        if (bus.xfer_cnt !== 16'(exp_xfer) || bus.count !== 3'd1) begin
            $display("FAIL held_done: xfer=%0d count=%0d, required %0d/1",
                     bus.xfer_cnt, bus.count, exp_xfer);
            fails++;
        end
        pop_check(8'h77, "held_data");
    endtask

    task automatic test_reset_mid();
        bus.data_in = 8'h3C;
        bus.send    = 1'b1;
        wait_ack(1'b1, "rstmid_rise");
        rst = 1'b1;
        #1;
        tests++;
        if (bus.ack !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0 ||
            bus.xfer_cnt !== 16'd0) begin
            $display("FAIL rstmid_in_reset: ack=%b count=%0d valid=%b xfer=%0d, required all 0",
                     bus.ack, bus.count, bus.out_valid, bus.xfer_cnt);
            fails++;
        end
        @(negedge clk);
        rst      = 1'b0;
        exp_xfer = 0;
        wait_ack(1'b1, "rstmid_reaccept");
        tests++;
        if (bus.count !== 3'd1 || bus.out_data !== 8'h3C || bus.xfer_cnt !== 16'd0) begin
            $display("FAIL rstmid_new_push: count=%0d data=%h xfer=%0d, required 1/3c/0",
                     bus.count, bus.out_data, bus.xfer_cnt);
            fails++;
        end
        bus.send = 1'b0;
        wait_ack(1'b0, "rstmid_fall");
        exp_xfer++;
        tests++;
        if (bus.xfer_cnt !== 16'd1) begin
            $display("FAIL rstmid_xfer: xfer=%0d, required 1", bus.xfer_cnt);
            fails++;
        end
        pop_check(8'h3C, "rstmid_data");
    endtask

    task automatic test_wrap();
        rx_q.delete();
        bus.out_ready = 1'b1;
        mon_en        = 1'b1;
        for (int i = 0; i < 13; i++) send_word(8'h40 + 8'(i));
        repeat (3) @(negedge clk);
        mon_en        = 1'b0;
        bus.out_ready = 1'b0;
        tests++;
        if (rx_q.size() != 13 || bus.count !== 3'd0) begin
            $display("FAIL wrap_count: received=%0d count=%0d, required 13/0", rx_q.size(), bus.count);
            fails++;
        end
        for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== 8'h40 + 8'(i)) begin
                $display("FAIL wrap_order[%0d]: data=%h, required %h", i, rx_q[i], 8'h40 + 8'(i));
                fails++;
            end
        end
        tests++;
        if (bus.xfer_cnt !== 16'(exp_xfer)) begin
            $display("FAIL wrap_xfer: xfer=%0d, required %0d", bus.xfer_cnt, exp_xfer);
            fails++;
        end
    endtask

    initial begin
        bus.send      = 1'b0;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_simultaneous();
        test_held();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
